// File: rtl/pim_gemm_sched_if.sv
// Host/crossbar/result bundle for the PIM GEMM scheduler.
// The master side is the job host and crossbar; the slave side is the scheduler.
interface pim_gemm_sched_if #(
  parameter int INPUT_P = 16,
  parameter int DEPTH   = 100,
  parameter int ADC_P   = 8,
  parameter int OUT_P   = 16
);
  localparam int NB = INPUT_P / 2;
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int BW = (NB > 2) ? $clog2(NB) : 1;

  logic             start;
  logic [AW-1:0]    start_addr;
  logic [AW-1:0]    end_addr;
  logic [AW-1:0]    pim_addr;
  logic [BW-1:0]    bit_cnt;
  logic             pim_en;
  logic [ADC_P-1:0] adc_sum;
  logic [OUT_P-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, start_addr, end_addr,
    output adc_sum, out_ready,
    input  pim_addr, bit_cnt, pim_en,
    input  out_data, out_valid, busy, done
  );

  modport slave (
    input  start, start_addr, end_addr,
    input  adc_sum, out_ready,
    output pim_addr, bit_cnt, pim_en,
    output out_data, out_valid, busy, done
  );
endinterface

// File: rtl/pim_gemm_sched.sv
// Bit-serial row scheduler for a PIM crossbar: issues slices,
// shift-accumulates the delayed ADC sums and emits one result per row.
module pim_gemm_sched #(
  parameter int INPUT_P = 16,
  parameter int DEPTH   = 100,
  parameter int ADC_P   = 8,
  parameter int OUT_P   = 16,
  parameter int ADC_LAT = 1
) (
  input logic clk,
  input logic rst,
  pim_gemm_sched_if.slave bus
);
  localparam int NB    = INPUT_P / 2;
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int BW    = (NB > 2) ? $clog2(NB) : 1;
  localparam int ACC_W = ADC_P + NB;
  localparam int SW    = (ACC_W > OUT_P) ? ACC_W : OUT_P;
  localparam int DW    = (ADC_LAT > 1) ? $clog2(ADC_LAT) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] EMIT  = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [AW-1:0]    LAST_ROW = AW'(DEPTH - 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(NB - 1);
  localparam logic [DW-1:0]    LAST_DRN = DW'(ADC_LAT - 1);
  localparam logic [OUT_P-1:0] OUT_MAX  = '1;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    end_q, end_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_P-1:0] out_q, out_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic [ADC_LAT-1:0] dv_q;
  logic [BW-1:0]    db_q [ADC_LAT];

  logic          st_idle, st_run, st_drain;
  logic          st_emit, st_fin;
  logic [AW-1:0] end_clamp;
  logic [SW-1:0] acc_x;

  assign st_idle  = (state_q == IDLE);
  assign st_run   = (state_q == RUN);
  assign st_drain = (state_q == DRAIN);
  assign st_emit  = (state_q == EMIT);
  assign st_fin   = (state_q == FIN);

  assign end_clamp = (bus.end_addr > LAST_ROW) ?
                     LAST_ROW : bus.end_addr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    drn_d   = drn_q;
    // the slice leaving the delay line lines up with adc_sum
    if (dv_q[ADC_LAT-1]) begin
      acc_d = acc_q +
        (ACC_W'(bus.adc_sum) << db_q[ADC_LAT-1]);
    end
    unique case (1'b1)
      st_idle: begin
        if (bus.start) begin
          acc_d = '0;
          end_d = end_clamp;
          if (bus.start_addr > end_clamp) begin
            state_d = FIN;
          end else begin
            addr_d  = bus.start_addr;
            bit_d   = '0;
            state_d = RUN;
          end
        end
      end
      st_run: begin
        if (bit_q == LAST_BIT) begin
          drn_d   = '0;
          state_d = DRAIN;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      st_drain: begin
        if (drn_q == LAST_DRN) begin
          state_d = EMIT;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      st_emit: begin
        if (bus.out_ready) begin
          if (addr_q == end_q) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            acc_d   = '0;
            bit_d   = '0;
            state_d = RUN;
          end
        end
      end
      st_fin: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_x = SW'(acc_d);
  assign out_d = (acc_x > SW'(OUT_MAX)) ?
                 OUT_MAX : acc_x[OUT_P-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      bit_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      drn_q   <= drn_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q <= '0;
      for (int i = 0; i < ADC_LAT; i++) begin
        db_q[i] <= '0;
      end
    end else begin
      dv_q[0] <= st_run;
      db_q[0] <= bit_q;
      for (int i = 1; i < ADC_LAT; i++) begin
        dv_q[i] <= dv_q[i-1];
        db_q[i] <= db_q[i-1];
      end
    end
  end

  assign bus.pim_addr  = addr_q;
  assign bus.bit_cnt   = bit_q;
  assign bus.pim_en    = st_run;
  assign bus.out_data  = out_q;
  assign bus.out_valid = st_emit;
  assign bus.busy      = !st_idle;
  assign bus.done      = st_fin;

endmodule

// File: doc/pim_gemm_sched.md
PIM_GEMM_SCHED -- requirements
Module: pim_gemm_sched

Interface
REQ-001 Parameter: INPUT_P, 16, input word width; INPUT_P/2 bit-serial steps per row (NB = INPUT_P/2).
REQ-002 Parameter: DEPTH, 100, crossbar rows; AW = clogb2(DEPTH) address bits.
REQ-003 Parameter: ADC_P, 8, width of the summed crossbar ADC result.
REQ-004 Parameter: OUT_P, 16, result width.
REQ-005 Parameter: ADC_LAT, 1, cycles from pim_en/bit_cnt issue to a valid adc_sum.
REQ-006 One clock and one reset; reset is asynchronous and active-low.
REQ-007 clk  in  1  the single clock; all state is updated on its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  single-cycle job request.
REQ-010 start_addr  in  AW  first crossbar row of the job.
REQ-011 end_addr  in  AW  last crossbar row of the job (inclusive).
REQ-012 pim_addr  out  AW  row address driven to the crossbar.
REQ-013 bit_cnt  out  clogb2(NB-1)  input bit-slice index driven to the crossbar.
REQ-014 pim_en  out  1  crossbar compute enable, high for each issued slice.
REQ-015 adc_sum  in  ADC_P  summed HH/HL/LH/LL ADC output, treated as unsigned.
REQ-016 out_data  out  OUT_P  accumulated row result.
REQ-017 out_valid  out  1  out_data holds a valid row result.
REQ-018 out_ready  in  1  downstream accepts the result.
REQ-019 busy  out  1  a job is in progress.
REQ-020 done  out  1  one-cycle pulse when a job completes.

Function
REQ-021 The FSM SHALL have the states IDLE, RUN, DRAIN, EMIT and FIN.
REQ-022 IDLE: start=1 SHALL latch start_addr/end_addr (end clamped to DEPTH-1), clear acc, and go to RUN next cycle.
REQ-023 Start requests in any state other than IDLE SHALL be ignored.
REQ-024 If start_addr > end_addr (after clamp), IDLE SHALL go directly to FIN with no pim_en and no out_valid.
REQ-025 RUN: each cycle SHALL assert pim_en with pim_addr = current row and bit_cnt = 0..NB-1, incrementing by one per cycle.
REQ-026 After bit_cnt = NB-1 has been issued, RUN SHALL go to DRAIN.
REQ-027 Issued bit indices SHALL be delayed ADC_LAT cycles; when each delayed slice is valid, acc <= acc + (adc_sum << delayed_bit).
REQ-028 The accumulator SHALL be ADC_P+NB bits wide and SHALL never wrap.
REQ-029 out_data SHALL be acc saturated to 2^OUT_P-1.
REQ-030 DRAIN SHALL last ADC_LAT cycles with pim_en=0, then go to EMIT.
REQ-031 EMIT SHALL hold out_valid=1 and out_data stable until out_ready=1.
REQ-032 On the out_ready handshake in EMIT:
- last row: go to FIN;
- otherwise: pim_addr+1, clear acc, bit_cnt=0, go to RUN.
REQ-033 A handshake SHALL occur only in a cycle where out_valid and out_ready are both 1; out_ready while out_valid=0 SHALL be ignored.
REQ-034 FIN SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-035 busy SHALL be 1 in RUN, DRAIN, EMIT and FIN, and 0 in IDLE.
REQ-036 pim_en SHALL be 0 outside RUN.
REQ-037 pim_addr/bit_cnt SHALL hold their last values outside RUN.
REQ-038 Latency: first out_valid SHALL rise NB+ADC_LAT+1 cycles after the start-accept edge.

Reset
REQ-039 rst=0 SHALL immediately force state=IDLE and clear all of the following: pim_addr, bit_cnt, pim_en, acc, out_data, out_valid, busy, done.
REQ-040 Reset mid-job SHALL abandon the job with no done pulse.
REQ-041 After reset release, a new start SHALL be required before any further activity.

Verification
REQ-042 start, addr 5..5, adc_sum=1 constant, out_ready=1 -> pim_en cycles 1-8, bit_cnt 0..7, out_valid at cycle 10, out_data=0x00FF, done once.
REQ-043 addr 0..2, adc_sum=0xFF -> three results of 0xFF*255=0xFE01 each, pim_addr 0,1,2, single done after third handshake.
REQ-044 out_ready held 0 for 20 cycles in EMIT -> out_valid held high, out_data stable, pim_en=0 throughout, then resume on out_ready.
REQ-045 start_addr=9, end_addr=3 -> no pim_en, no out_valid, done pulse, busy high for exactly one cycle (FIN).
REQ-046 rst=0 asserted during RUN at bit_cnt=4 -> outputs cleared asynchronously, no done; new start runs normally.
REQ-047 start pulsed while busy -> ignored, job addresses unchanged.
